// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: data-memory req/ack bus; master drives request/we/addr/be/wdata, slave returns ack/rdata
interface lsu_ctrl_if #(parameter int ADDR_W = 32);
  logic bus_req;
  logic bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0] bus_be;
  logic [31:0] bus_wdata;
  logic bus_ack;
  logic [31:0] bus_rdata;
  modport master(output bus_req, bus_we, bus_addr, bus_be, bus_wdata, input bus_ack, bus_rdata);
  modport slave(input bus_req, bus_we, bus_addr, bus_be, bus_wdata, output bus_ack, bus_rdata);
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store sequencer; in: clk, rst, mem_valid_M/we_mem_M/ls_type_M/addr_M/wdata_M; out: stall_M, rdata_M, load_done_M, misalign_M, bus_err_M; bus: lsu_ctrl_if.master; define LSU_TIMEOUT_EN to abort after TIMEOUT_CYCLES unacked ACCESS cycles
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_M,
  input  logic              we_mem_M,
  input  logic [2:0]        ls_type_M,
  input  logic [ADDR_W-1:0] addr_M,
  input  logic [31:0]       wdata_M,
  output logic              stall_M,
  output logic [31:0]       rdata_M,
  output logic              load_done_M,
  output logic              misalign_M,
  output logic              bus_err_M,
  lsu_ctrl_if.master        bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;
  state_t state, state_n;
  logic we_q;
  logic [2:0] type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0] be_q, be_n;
  logic [31:0] wdata_q, wdata_n, rdata_q, ext;
  logic [1:0] o, sz;
  logic illegal, misal, fault, timeout;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  assign o = addr_M[1:0];
  assign sz = ls_type_M[1:0];
  always_comb begin
    illegal = (sz == 2'b11) | (ls_type_M[2] & (we_mem_M | ls_type_M[1]));
    misal = sz == 2'b01 ? o[0] : sz == 2'b10 ? |o : 1'b0;
    fault = illegal | misal;
    be_n = sz == 2'b00 ? 4'b0001 << o : sz == 2'b01 ? 4'b0011 << o : 4'b1111;
    wdata_n = sz == 2'b00 ? {4{wdata_M[7:0]}} : sz == 2'b01 ? {2{wdata_M[15:0]}} : wdata_M;
  end
  always_comb begin
    byte_v = bus.bus_rdata[8*addr_q[1:0] +: 8];
    half_v = bus.bus_rdata[16*addr_q[1] +: 16];
    ext = type_q[1:0] == 2'b00 ? {{24{~type_q[2] & byte_v[7]}}, byte_v}
        : type_q[1:0] == 2'b01 ? {{16{~type_q[2] & half_v[15]}}, half_v}
        : bus.bus_rdata;
  end
  always_comb begin
    state_n = state == IDLE ? (mem_valid_M ? (fault ? ERR : ACCESS) : IDLE)
            : state == ACCESS ? (bus.bus_ack ? DONE : timeout ? ERR : ACCESS)
            : IDLE;
    stall_M = (state == IDLE & mem_valid_M) | state == ACCESS;
    bus.bus_req = state == ACCESS;
    load_done_M = state == DONE & ~we_q;
  end
  assign bus.bus_we = we_q;
  assign bus.bus_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.bus_be = be_q;
  assign bus.bus_wdata = wdata_q;
  assign rdata_M = rdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      we_q <= 1'b0;
      type_q <= '0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && mem_valid_M && !fault) begin
        we_q <= we_mem_M;
        type_q <= ls_type_M;
        addr_q <= addr_M;
        be_q <= be_n;
        wdata_q <= wdata_n;
      end
      if (state == ACCESS && bus.bus_ack && !we_q) rdata_q <= ext;
      else if (state_n == ERR) rdata_q <= '0;
    end
  end
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic from_access;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign bus_err_M = state == ERR & from_access;
  assign misalign_M = state == ERR & ~from_access;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      from_access <= 1'b0;
    end else begin
      cnt <= state == ACCESS ? cnt + CW'(1) : '0;
      from_access <= state == ACCESS;
    end
  end
`else
  assign timeout = TIMEOUT_CYCLES < 0;
  assign bus_err_M = 1'b0;
  assign misalign_M = state == ERR;
`endif
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized and directed checks of lsu_ctrl against a byte-arithmetic reference model
module tb_lsu_ctrl;
  logic clk = 0, rst = 1;
  logic mem_valid_M = 0, we_mem_M = 0;
  logic [2:0] ls_type_M = '0;
  logic [31:0] addr_M = '0, wdata_M = '0;
  logic stall_M, load_done_M, misalign_M, bus_err_M;
  logic [31:0] rdata_M;
  int total = 0, bad = 0;
  int o_stall, o_req, o_done, o_mis, o_err;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0] o_be;
  logic o_we, o_unstable, o_hung;
  lsu_ctrl_if #(.ADDR_W(32)) bif();
  lsu_ctrl #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_valid_M(mem_valid_M), .we_mem_M(we_mem_M), .ls_type_M(ls_type_M),
    .addr_M(addr_M), .wdata_M(wdata_M), .stall_M(stall_M), .rdata_M(rdata_M),
    .load_done_M(load_done_M), .misalign_M(misalign_M), .bus_err_M(bus_err_M), .bus(bif.master)
  );
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int m_size(input logic [2:0] t);
    return 1 << (t % 4);
  endfunction
  function automatic logic m_fault(input logic we, input logic [2:0] t, input logic [31:0] a);
    if (we ? t > 2 : (t == 3 || t > 5)) return 1'b1;
    return (a % m_size(t)) != 0;
  endfunction
  function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
    return 4'(((1 << m_size(t)) - 1) << (a % 4));
  endfunction
  function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] w);
    if (m_size(t) == 1) return (w & 32'hFF) * 32'h01010101;
    if (m_size(t) == 2) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd);
    int n;
    logic [31:0] v;
    n = m_size(t);
    v = rd >> (8 * (a % 4));
    if (n == 4) return v;
    v = v & ((32'd1 << (8 * n)) - 1);
    if (t < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic run_op(input logic we, input logic [2:0] t, input logic [31:0] a, w, rd, input int dly);
    int rq;
    bit fin;
    o_stall = 0; o_req = 0; o_done = 0; o_mis = 0; o_err = 0; o_rdata = '0;
    o_addr = '0; o_wdata = '0; o_be = '0; o_we = 0; o_unstable = 0; o_hung = 1;
    @(negedge clk);
    mem_valid_M = 1; we_mem_M = we; ls_type_M = t; addr_M = a; wdata_M = w;
    bif.bus_rdata = rd; bif.bus_ack = 0;
    rq = 0;
    for (int c = 0; c < 60; c++) begin
      if (bif.bus_req) begin
        rq++;
        if (rq == 1) begin
          o_be = bif.bus_be; o_addr = bif.bus_addr; o_wdata = bif.bus_wdata; o_we = bif.bus_we;
        end else if ({o_be, o_addr, o_wdata, o_we} !== {bif.bus_be, bif.bus_addr, bif.bus_wdata, bif.bus_we})
          o_unstable = 1;
      end
      bif.bus_ack = bif.bus_req && rq == dly;
      #1;
      o_stall += int'(stall_M); o_done += int'(load_done_M); o_mis += int'(misalign_M); o_err += int'(bus_err_M);
      if (load_done_M || misalign_M) o_rdata = rdata_M;
      fin = !stall_M;
      @(negedge clk);
      if (fin) begin
        o_hung = 0;
        break;
      end
    end
    o_req = rq;
    mem_valid_M = 0; bif.bus_ack = 0;
    #1;
    o_stall += int'(stall_M); o_done += int'(load_done_M); o_mis += int'(misalign_M); o_err += int'(bus_err_M);
    o_req += int'(bif.bus_req);
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({stall_M, load_done_M, misalign_M, bus_err_M, bif.bus_req, bif.bus_we} !== 6'b0 ||
        {rdata_M, bif.bus_addr, bif.bus_wdata, bif.bus_be} !== 100'b0) begin
      bad++; $display("FAIL reset_outputs: stall=%b req=%b rdata=%h addr=%h be=%b want all 0", stall_M, bif.bus_req, rdata_M, bif.bus_addr, bif.bus_be);
    end
    @(negedge clk);
    rst = 0;
    #1;
    total++;
    if ({stall_M, bif.bus_req, load_done_M, misalign_M} !== 4'b0) begin
      bad++; $display("FAIL reset_release: stall=%b req=%b want 0", stall_M, bif.bus_req);
    end
  endtask

  task automatic test_lb_lbu;
    run_op(0, 3'b000, 32'h1003, 32'h0, 32'h80AABBCC, 1);
    total++;
    if (o_be !== 4'b1000 || o_stall !== 2 || o_done !== 1 || o_hung !== 0) begin
      bad++; $display("FAIL lb_handshake: be=%b stall=%0d done=%0d want 1000/2/1", o_be, o_stall, o_done);
    end
    total++;
    if (o_rdata !== 32'hFFFFFF80) begin
      bad++; $display("FAIL lb_rdata: got %h want ffffff80", o_rdata);
    end
    run_op(0, 3'b100, 32'h1003, 32'h0, 32'h80AABBCC, 1);
    total++;
    if (o_rdata !== 32'h00000080 || o_done !== 1) begin
      bad++; $display("FAIL lbu_rdata: got %h done=%0d want 00000080/1", o_rdata, o_done);
    end
  endtask

  task automatic test_sh;
    run_op(1, 3'b001, 32'h2002, 32'hDEAD1234, 32'h0, 1);
    total++;
    if (o_we !== 1'b1 || o_be !== 4'b1100 || o_addr !== 32'h2000) begin
      bad++; $display("FAIL sh_bus: we=%b be=%b addr=%h want 1/1100/2000", o_we, o_be, o_addr);
    end
    total++;
    if (o_wdata !== 32'h12341234 || o_done !== 0 || o_stall !== 2) begin
      bad++; $display("FAIL sh_data: wdata=%h done=%0d stall=%0d want 12341234/0/2", o_wdata, o_done, o_stall);
    end
  endtask

  task automatic test_misalign;
    run_op(0, 3'b010, 32'h3001, 32'h0, 32'h0, 1);
    total++;
    if (o_mis !== 1 || o_req !== 0 || o_stall !== 1 || o_done !== 0 || o_err !== 0) begin
      bad++; $display("FAIL lw_misalign: mis=%0d req=%0d stall=%0d done=%0d want 1/0/1/0", o_mis, o_req, o_stall, o_done);
    end
    run_op(0, 3'b011, 32'h3000, 32'h0, 32'h0, 1);
    total++;
    if (o_mis !== 1 || o_req !== 0 || o_stall !== 1 || o_done !== 0 || o_rdata !== 32'h0) begin
      bad++; $display("FAIL illegal_type: mis=%0d req=%0d stall=%0d rdata=%h want 1/0/1/0", o_mis, o_req, o_stall, o_rdata);
    end
  endtask

  task automatic test_lhu_delay;
    run_op(0, 3'b101, 32'h4002, 32'h0, 32'hF00F0000, 5);
    total++;
    if (o_stall !== 6 || o_req !== 5 || o_unstable !== 0) begin
      bad++; $display("FAIL lhu_delay: stall=%0d req=%0d unstable=%b want 6/5/0", o_stall, o_req, o_unstable);
    end
    total++;
    if (o_rdata !== 32'h0000F00F || o_be !== 4'b1100) begin
      bad++; $display("FAIL lhu_rdata: got %h be=%b want 0000f00f/1100", o_rdata, o_be);
    end
  endtask

  task automatic test_rst_mid;
    int rq = 0;
    @(negedge clk);
    mem_valid_M = 1; we_mem_M = 0; ls_type_M = 3'b010; addr_M = 32'h40; bif.bus_ack = 0;
    for (int c = 0; c < 10 && rq < 3; c++) begin
      @(negedge clk);
      if (bif.bus_req) rq++;
    end
    rst = 1;
    @(negedge clk);
    rst = 0; mem_valid_M = 0;
    #1;
    total++;
    if (rq !== 3 || {stall_M, bif.bus_req, load_done_M, misalign_M, bus_err_M, bif.bus_we} !== 6'b0 ||
        {rdata_M, bif.bus_addr, bif.bus_be, bif.bus_wdata} !== 100'b0) begin
      bad++; $display("FAIL rst_mid: rq=%0d stall=%b req=%b addr=%h be=%b want 3 and all 0", rq, stall_M, bif.bus_req, bif.bus_addr, bif.bus_be);
    end
    bif.bus_ack = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      total++;
      if ({stall_M, bif.bus_req, load_done_M, misalign_M} !== 4'b0) begin
        bad++; $display("FAIL stray_ack: stall=%b req=%b done=%b want 0", stall_M, bif.bus_req, load_done_M);
      end
    end
    bif.bus_ack = 0;
  endtask

  task automatic test_back_to_back;
    int rq = 0;
    run_op(0, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 1);
    total++;
    if (o_rdata !== 32'hCAFEF00D || o_done !== 1) begin
      bad++; $display("FAIL b2b_first: rdata=%h done=%0d want cafef00d/1", o_rdata, o_done);
    end
    @(negedge clk);
    mem_valid_M = 1; we_mem_M = 0; ls_type_M = 3'b010; addr_M = 32'h104; bif.bus_rdata = 32'h11223344;
    for (int c = 0; c < 20 && !load_done_M; c++) begin
      bif.bus_ack = bif.bus_req;
      #1;
      rq += int'(bif.bus_req);
      if (!load_done_M) @(negedge clk);
    end
    total++;
    if (load_done_M !== 1'b1 || rdata_M !== 32'h11223344 || rq !== 1) begin
      bad++; $display("FAIL b2b_second: done=%b rdata=%h req=%0d want 1/11223344/1", load_done_M, rdata_M, rq);
    end
    @(negedge clk);
    #1;
    total++;
    if (stall_M !== 1'b1 || bif.bus_req !== 1'b0) begin
      bad++; $display("FAIL done_to_idle: stall=%b req=%b want 1/0", stall_M, bif.bus_req);
    end
    mem_valid_M = 0; bif.bus_ack = 0;
    @(negedge clk);
    @(negedge clk);
    bif.bus_ack = bif.bus_req;
    @(negedge clk);
    bif.bus_ack = 0;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic we;
    logic [2:0] t;
    logic [31:0] a, w, rd, ew;
    int dly;
    bit f;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1)); t = 3'($urandom_range(0, 7));
      a = 32'h800 + $urandom_range(0, 63); w = $urandom; rd = $urandom; dly = $urandom_range(1, 4);
      f = m_fault(we, t, a);
      run_op(we, t, a, w, rd, dly);
      total++;
      if (f) begin
        if (o_mis !== 1 || o_req !== 0 || o_stall !== 1 || o_done !== 0 || o_rdata !== 32'h0) begin
          bad++; $display("FAIL rand_fault[%0d]: we=%b t=%0d a=%h mis=%0d req=%0d stall=%0d", i, we, t, a, o_mis, o_req, o_stall);
        end
      end else begin
        ew = we ? m_wdata(t, w) : o_wdata;
        if (o_be !== m_be(t, a) || o_addr !== a - (a % 4) || o_we !== we || o_wdata !== ew ||
            o_stall !== dly + 1 || o_req !== dly || o_mis !== 0 || o_unstable !== 0 ||
            o_done !== int'(!we) || o_rdata !== (we ? 32'h0 : m_load(t, a, rd))) begin
          bad++; $display("FAIL rand_op[%0d]: we=%b t=%0d a=%h be=%b/%b wd=%h/%h rd=%h/%h stall=%0d/%0d", i, we, t, a,
                          o_be, m_be(t, a), o_wdata, ew, o_rdata, we ? 32'h0 : m_load(t, a, rd), o_stall, dly + 1);
        end
      end
    end
  endtask

  task automatic test_timeout;
`ifdef LSU_TIMEOUT_EN
    run_op(0, 3'b010, 32'h500, 32'h0, 32'h0, 100);
    total++;
    if (o_req !== 4 || o_err !== 1 || o_mis !== 0 || o_done !== 0 || o_stall !== 5 || o_hung !== 0) begin
      bad++; $display("FAIL timeout: req=%0d err=%0d mis=%0d stall=%0d want 4/1/0/5", o_req, o_err, o_mis, o_stall);
    end
    run_op(0, 3'b010, 32'h504, 32'h0, 32'h5A5A5A5A, 4);
    total++;
    if (o_done !== 1 || o_err !== 0 || o_rdata !== 32'h5A5A5A5A) begin
      bad++; $display("FAIL ack_at_limit: done=%0d err=%0d rdata=%h want 1/0/5a5a5a5a", o_done, o_err, o_rdata);
    end
`else
    run_op(0, 3'b010, 32'h500, 32'h0, 32'h13579BDF, 20);
    total++;
    if (o_req !== 20 || o_err !== 0 || o_done !== 1 || o_rdata !== 32'h13579BDF) begin
      bad++; $display("FAIL long_wait: req=%0d err=%0d done=%0d want 20/0/1", o_req, o_err, o_done);
    end
`endif
  endtask

  initial begin
    bif.bus_ack = 0;
    bif.bus_rdata = '0;
    test_reset;
    test_lb_lbu;
    test_sh;
    test_misalign;
    test_lhu_delay;
    test_rst_mid;
    test_back_to_back;
    test_timeout;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store sequencer for the MEM stage. It takes the decoded memory operation (we_mem, ls_type, address, store data) and runs a req/ack transaction on the data-memory bus. It generates byte enables and lane-replicated store data, and sign- or zero-extends load data. It stalls the pipeline until the access completes and flags misaligned or illegal accesses without touching the bus.

Parameters:
TIMEOUT_CYCLES, 255, bus wait cycles before abort (used only with LSU_TIMEOUT_EN)
ADDR_W, 32, address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
mem_valid_M  in  1  MEM-stage instruction is a load/store; held stable while stall_M=1
we_mem_M  in  1  1=store, 0=load
ls_type_M  in  3  load: LB 000, LH 001, LW 010, LBU 100, LHU 101; store: SB 000, SH 001, SW 010
addr_M  in  ADDR_W  effective byte address
wdata_M  in  32  store data (rs2 value)
stall_M  out  1  hold IF..MEM stages
rdata_M  out  32  extended load result, valid when load_done_M=1
load_done_M  out  1  one-cycle pulse, load result valid
misalign_M  out  1  one-cycle pulse, misaligned or illegal ls_type
bus_err_M  out  1  one-cycle pulse, bus timeout (0 without LSU_TIMEOUT_EN)
bus_req  out  1  bus request, held until bus_ack
bus_we  out  1  bus write
bus_addr  out  ADDR_W  word address {addr_M[ADDR_W-1:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  transaction complete; bus_rdata valid same cycle
bus_rdata  in  32  read word

Behaviour:
- States: IDLE, ACCESS, DONE, ERR. On rst: IDLE; all outputs 0, the counter 0, and captured registers 0.
- stall_M = (IDLE & mem_valid_M) | ACCESS. It is 0 in DONE and ERR, and 0 in IDLE without mem_valid_M.
- In IDLE with mem_valid_M:
  - Legal and aligned: capture addr, we, ls_type, bus_be, bus_wdata. Go to ACCESS.
  - Misaligned or illegal: go to ERR with no bus activity.
- Illegal cases: load ls_type 011/110/111; store ls_type other than 000/001/010. These go to ERR.
- Misaligned cases: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. These go to ERR.
- ACCESS: bus_req=1, with bus_we/addr/be/wdata driven from registers and stable for the whole request.
  - On bus_ack: drop bus_req next cycle. For a load, register the extended data into rdata_M. Go to DONE.
  - A bus_ack in IDLE, DONE or ERR is ignored.
- DONE: stall_M=0. load_done_M=1 if the access was a load. Next state is IDLE unconditionally; no restart on the still-asserted mem_valid_M.
- ERR: stall_M=0. Pulse misalign_M, or bus_err_M if entered on timeout; rdata_M=0. Next state is IDLE.
- Byte enables, with o=addr[1:0]:
  - SB/LB/LBU: 4'b0001<<o.
  - SH/LH/LHU: 4'b0011<<o.
  - SW/LW: 4'b1111.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extension:
  - Byte = bus_rdata[8*o+7:8*o]; half = bus_rdata[16*o[1]+15:16*o[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
- Latency: valid seen in cycle 0, ack in cycle k (k≥1), result and DONE in cycle k+1. stall_M is high for k+1 cycles; minimum occupancy is 3 cycles.
- rst asserted in any state, including mid-ACCESS: next cycle is IDLE with bus_req=0. The in-flight transaction is abandoned and the bus owner must tolerate the dropped req.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without bus_ack. When it reaches TIMEOUT_CYCLES, bus_req drops and the FSM goes to ERR with bus_err_M=1 for one cycle and stall_M=0. If bus_ack arrives in the same cycle the count hits the limit, the ack wins and the FSM goes to DONE.
- Undefined: no counter. ACCESS waits indefinitely and bus_err_M is tied to 0.

Test Plan:
- LB, addr 0x1003, bus_rdata 0x80AABBCC, ack on first ACCESS cycle -> bus_be=1000, stall_M high 2 cycles, load_done_M pulse, rdata_M=0xFFFFFF80; repeat as LBU -> 0x00000080.
- SH, addr 0x2002, wdata 0xDEAD1234 -> bus_we=1, bus_be=1100, bus_wdata=0x12341234, bus_addr=0x2000, no load_done_M.
- LW, addr 0x3001 -> misalign_M pulse 1 cycle, bus_req never asserted, stall_M high 1 cycle; load ls_type 011 gives the same response.
- LHU, addr 0x4002, ack delayed 5 cycles after bus_req rises, bus_rdata 0xF00F0000 -> stall_M high 6 cycles, bus_req stable for 5 cycles, rdata_M=0x0000F00F.
- rst asserted on the 3rd ACCESS cycle -> next cycle IDLE, bus_req=0, stall_M=0, all outputs 0; a later ack is ignored.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> bus_req drops after 4 ACCESS cycles, bus_err_M pulses once, FSM returns to IDLE.
